// File: rtl/qlal4s3b_pkg.sv
// Shared widths, reset defaults and types for the cell-macro clock/reset model.
package qlal4s3b_pkg;
   localparam int DIV_W    = 8;
   localparam int RSTCNT_W = 4;

   localparam logic [DIV_W-1:0] DIV0_INIT_DEF = 8'd0;
   localparam logic [DIV_W-1:0] DIV1_INIT_DEF = 8'd11;

   typedef enum logic {
      CH0 = 1'b0,
      CH1 = 1'b1
   } chan_sel_e;

   typedef enum logic {
      ST_RST = 1'b0,
      ST_RUN = 1'b1
   } rst_st_e;

   typedef struct packed {
      logic             wr;
      logic [DIV_W-1:0] div;
   } chan_wr_t;
endpackage

// File: rtl/qlal4s3b_cell_macro_model_if.sv
// Divisor configuration bus between fabric and the clock/reset service.
interface qlal4s3b_cell_macro_model_if;
   import qlal4s3b_pkg::*;

   logic             cfg_wr;
   logic             cfg_sel;
   logic [DIV_W-1:0] cfg_div;

   modport master (output cfg_wr, output cfg_sel, output cfg_div);
   modport slave  (input  cfg_wr, input  cfg_sel, input  cfg_div);
endinterface

// File: rtl/qlal4s3b_clk_div.sv
// One divided-clock channel: toggle counter, boundary-aligned divisor update
// and a reset sequencer that releases on a falling toggle.
module qlal4s3b_clk_div
   import qlal4s3b_pkg::*;
#(
   parameter logic [DIV_W-1:0] DIV_INIT   = '0,
   parameter int               RST_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             sys_clk,
   output logic             sys_rst
);
   localparam logic [RSTCNT_W-1:0] RST_LIM = RSTCNT_W'(RST_CYCLES);

   logic [DIV_W-1:0]    cnt, div, pend;
   logic                pending, clk_q;
   logic [RSTCNT_W-1:0] rcnt;
   rst_st_e             state, state_nx;
   logic                toggle, rise, fall;

   assign toggle = (cnt == div);
   assign rise   = toggle & ~clk_q;
   assign fall   = toggle &  clk_q;

   // A write landing on a falling-toggle edge must survive the clear of the
   // flag done by that same edge, so the write assignments come last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         div     <= DIV_INIT;
         pend    <= DIV_INIT;
         pending <= 1'b0;
         clk_q   <= 1'b0;
         rcnt    <= '0;
      end else begin
         if (toggle) begin
            clk_q <= ~clk_q;
            cnt   <= '0;
            if (fall && pending) begin
               div     <= pend;
               pending <= 1'b0;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (wr) begin
            pend    <= wr_div;
            pending <= 1'b1;
         end
         if (state == ST_RST && rise && rcnt != RST_LIM)
            rcnt <= rcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RST;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_RST:  if (fall && rcnt == RST_LIM) state_nx = ST_RUN;
         ST_RUN:  state_nx = ST_RUN;
         default: state_nx = ST_RST;
      endcase
   end

   assign sys_clk = clk_q;
   assign sys_rst = (state == ST_RST);
endmodule

// File: rtl/qlal4s3b_cell_macro_model.sv
// EOS S3 cell-macro clock/reset service: two programmable divided clocks,
// each with its own synchronous-release reset, plus a combined ready flag.
module qlal4s3b_cell_macro_model
   import qlal4s3b_pkg::*;
#(
   parameter logic [DIV_W-1:0] DIV0_INIT  = DIV0_INIT_DEF,
   parameter logic [DIV_W-1:0] DIV1_INIT  = DIV1_INIT_DEF,
   parameter int               RST_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   qlal4s3b_cell_macro_model_if.slave    cfg,
   output logic                          Sys_Clk0,
   output logic                          Sys_Clk0_Rst,
   output logic                          Sys_Clk1,
   output logic                          Sys_Clk1_Rst,
   output logic                          clk_ready
);
   chan_wr_t wr0, wr1;

   assign wr0 = '{wr: cfg.cfg_wr & (cfg.cfg_sel == CH0), div: cfg.cfg_div};
   assign wr1 = '{wr: cfg.cfg_wr & (cfg.cfg_sel == CH1), div: cfg.cfg_div};

   qlal4s3b_clk_div #(.DIV_INIT(DIV0_INIT), .RST_CYCLES(RST_CYCLES)) u_ch0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr0.wr),
      .wr_div  (wr0.div),
      .sys_clk (Sys_Clk0),
      .sys_rst (Sys_Clk0_Rst)
   );

   qlal4s3b_clk_div #(.DIV_INIT(DIV1_INIT), .RST_CYCLES(RST_CYCLES)) u_ch1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr1.wr),
      .wr_div  (wr1.div),
      .sys_clk (Sys_Clk1),
      .sys_rst (Sys_Clk1_Rst)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clk_ready <= 1'b0;
      else        clk_ready <= ~Sys_Clk0_Rst & ~Sys_Clk1_Rst;
   end
endmodule

// File: tb/tb_qlal4s3b_cell_macro_model.sv
// Directed bench: reset/default waveform table plus reconfiguration,
// collision, mid-operation reset and extreme-divisor sequences.
module tb_qlal4s3b_cell_macro_model;
   logic clk, rst_n;
   logic Sys_Clk0, Sys_Clk0_Rst, Sys_Clk1, Sys_Clk1_Rst, clk_ready;

   qlal4s3b_cell_macro_model_if cif ();

   qlal4s3b_cell_macro_model dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg          (cif.slave),
      .Sys_Clk0     (Sys_Clk0),
      .Sys_Clk0_Rst (Sys_Clk0_Rst),
      .Sys_Clk1     (Sys_Clk1),
      .Sys_Clk1_Rst (Sys_Clk1_Rst),
      .clk_ready    (clk_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int   n;
      logic c0, r0, c1, r1, rdy;
   } vec_t;

   vec_t tbl[12];
   int   nvec = 0;
   int   nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic get(input int ch);
      return (ch != 0) ? Sys_Clk1 : Sys_Clk0;
   endfunction

   task automatic wr(input int ch, input int d);
      cif.cfg_sel = ch[0];
      cif.cfg_div = d[7:0];
      cif.cfg_wr  = 1'b1;
      step(1);
      cif.cfg_wr  = 1'b0;
   endtask

   task automatic wait_rise(input int ch);
      logic prev;
      int   k;
      prev = get(ch);
      for (k = 0; k < 1200; k++) begin
         step(1);
         if (!prev && get(ch)) break;
         prev = get(ch);
      end
      if (k == 1200) chk("rise_timeout", 1, 0);
   endtask

   task automatic meas(input int ch, output int hi, output int lo);
      wait_rise(ch);
      hi = 0;
      while (get(ch) == 1'b1 && hi < 1000) begin hi++; step(1); end
      lo = 0;
      while (get(ch) == 1'b0 && lo < 1000) begin lo++; step(1); end
   endtask

   task automatic chk_all(input string nm, input vec_t v);
      chk({nm, "_clk0"}, Sys_Clk0, v.c0);
      chk({nm, "_rst0"}, Sys_Clk0_Rst, v.r0);
      chk({nm, "_clk1"}, Sys_Clk1, v.c1);
      chk({nm, "_rst1"}, Sys_Clk1_Rst, v.r1);
      chk({nm, "_ready"}, clk_ready, v.rdy);
   endtask

   initial begin
      int hi, lo, cur;
      vec_t rv;

      // edges since release: expected Sys_Clk0, Rst0, Sys_Clk1, Rst1, ready
      tbl[0]  = '{0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{23, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{95, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{97, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      rv      = '{0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      rst_n       = 1'b0;
      cif.cfg_wr  = 1'b0;
      cif.cfg_sel = 1'b0;
      cif.cfg_div = 8'd0;
      step(3);
      chk_all("in_reset", rv);
      rst_n = 1'b1;

      cur = 0;
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].n - cur);
         cur = tbl[i].n;
         chk_all($sformatf("dflt_e%0d", tbl[i].n), tbl[i]);
      end

      // channel 0 to D=7, then D=3 written mid-high
      wr(0, 7);
      step(4);
      meas(0, hi, lo);
      chk("d7_hi", hi, 8);
      chk("d7_lo", lo, 8);
      wait_rise(0);
      step(2);
      wr(0, 3);
      step(4);
      chk("d3_still_hi", Sys_Clk0, 1);
      step(1);
      chk("d3_fall", Sys_Clk0, 0);
      step(3);
      chk("d3_low4", Sys_Clk0, 0);
      step(1);
      chk("d3_rise", Sys_Clk0, 1);
      meas(0, hi, lo);
      chk("d3_hi", hi, 4);
      chk("d3_lo", lo, 4);

      // last write wins
      wait_rise(0);
      wr(0, 1);
      wr(0, 5);
      meas(0, hi, lo);
      chk("lww_hi", hi, 6);
      chk("lww_lo", lo, 6);

      // write coincident with a falling toggle
      wait_rise(0);
      step(5);
      wr(0, 2);
      chk("coll_fall", Sys_Clk0, 0);
      meas(0, hi, lo);
      chk("coll_hi_old", hi, 6);
      chk("coll_lo_new", lo, 3);
      meas(0, hi, lo);
      chk("coll_hi", hi, 3);
      chk("coll_lo", lo, 3);

      // mid-operation reset during a Sys_Clk1 high phase, pending write lost
      wait_rise(1);
      step(2);
      wr(1, 20);
      step(2);
      chk("mid_c1_hi", Sys_Clk1, 1);
      rst_n = 1'b0;
      #1;
      chk_all("mid_rst", rv);
      step(1);
      wr(1, 255);
      step(2);
      chk("rst_wr_ign_c1", Sys_Clk1, 0);
      rst_n = 1'b1;
      step(11);
      chk("post_e11_c1", Sys_Clk1, 0);
      step(1);
      chk("post_e12_c1", Sys_Clk1, 1);
      meas(1, hi, lo);
      chk("post_hi", hi, 12);
      chk("post_lo", lo, 12);

      // extreme divisor
      wr(1, 255);
      step(30);
      meas(1, hi, lo);
      chk("d255_hi", hi, 256);
      chk("d255_lo", lo, 256);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/qlal4s3b_cell_macro_model.md
# qlal4s3b_cell_macro_model

Synthesizable model of the EOS S3 cell-macro clock/reset service seen by fabric logic. It divides the fabric reference clock into two programmable system clocks, Sys_Clk0 and Sys_Clk1, and generates a matching reset for each, so fabric designs such as the LCD adder get a clock from this block instead of the hard macro.

## Interface
- DIV0_INIT, default 8'd0: reset value of the channel-0 half-period divisor. Sys_Clk0 starts at clk/2.
- DIV1_INIT, default 8'd11: reset value of the channel-1 half-period divisor. Sys_Clk1 starts at clk/24.
- RST_CYCLES, default 4: number of Sys_ClkN rising edges for which Sys_ClkN_Rst stays asserted after reset release. Legal range is 1..15.

Ports:
- clk, input, 1: fabric reference clock. Single clock domain.
- rst_n, input, 1: asynchronous, active-low reset.
- cfg_wr, input, 1: one-cycle strobe that writes cfg_sel/cfg_div.
- cfg_sel, input, 1: channel select, 0 = channel 0, 1 = channel 1.
- cfg_div, input, 8: new half-period divisor D.
- Sys_Clk0, output, 1: divided clock 0.
- Sys_Clk0_Rst, output, 1: active-high reset for the Sys_Clk0 domain.
- Sys_Clk1, output, 1: divided clock 1.
- Sys_Clk1_Rst, output, 1: active-high reset for the Sys_Clk1 domain.
- clk_ready, output, 1: high when both Sys_ClkN_Rst are low.

## Operation
- Each channel has a counter cnt[7:0], an active divisor div, a pending divisor pend, a pending flag, and a toggle register clk_q that drives Sys_ClkN.
- On each clk rising edge: if cnt == div, invert clk_q and set cnt to 0; otherwise increment cnt.
  - Period = 2·(div+1) clk cycles, 50 % duty.
  - div = 0 gives clk/2; div = 255 gives clk/512.
- A write (cfg_wr = 1) loads cfg_div into pend of the selected channel and sets its pending flag.
  - The last write before application wins.
- A pending divisor is applied only on a falling toggle (clk_q 1→0), which is the period boundary.
  - At that edge: div ← pend, pending flag cleared, cnt ← 0.
  - This rule means no runt or glitch pulse is ever produced.
- If cfg_wr coincides with a falling-toggle edge, the toggle uses the previously pending value (if any). The new write is applied at the next falling toggle.
- Reset generation: Sys_ClkN_Rst asserts asynchronously while rst_n = 0.
  - After release, the channel counts rising toggles of clk_q (0→1).
  - Sys_ClkN_Rst deasserts on the falling toggle that follows the RST_CYCLES-th rising toggle. Release is therefore aligned with Sys_ClkN low.
- rst_n asserted mid-operation: all state returns to reset values immediately, including any pending write, which is lost.
- cfg_wr is ignored while rst_n = 0. Writes while Sys_ClkN_Rst is high are accepted.

## Timing
- Reset values:
  - Sys_Clk0 = Sys_Clk1 = 0.
  - Sys_Clk0_Rst = Sys_Clk1_Rst = 1.
  - clk_ready = 0.
  - cnt = 0, pend = div = DIVn_INIT, pending = 0, rising-edge counters = 0.
- The first rising toggle of a channel occurs at clk edge (div+1) after rst_n release. Later toggles occur every div+1 edges.
- All outputs are registered on clk; there is no combinational path from inputs.
- Divisor write latency: the new period starts at the first falling toggle strictly after the write edge.
- clk_ready rises one clk cycle after the later of the two reset deassertions.

## Structure
- Shared package qlal4s3b_pkg holds:
  - DIV_W = 8.
  - RSTCNT_W = 4.
  - Default constants DIV0_INIT_DEF = 0 and DIV1_INIT_DEF = 11.
- One sub-module, qlal4s3b_clk_div, instantiated twice. It contains the counter, toggle, pending-divisor logic and reset sequencer.
- The top level decodes cfg_sel and generates clk_ready.

## Test plan
- Reset, defaults: release rst_n.
  - Sys_Clk0 rises at edges 1, 3, 5, 7 and falls at 2, 4, 6, 8; Sys_Clk0_Rst falls after edge 8.
  - Sys_Clk1 rises at edge 12 and falls at edge 24.
- Ready sequencing: after the Sys_Clk1 reset release, clk_ready = 1 one cycle later.
- Reconfigure channel 0: cfg_sel = 0, cfg_div = 3 written mid-high phase.
  - The current half-period completes unchanged.
  - After the falling toggle, the period is 8 clk with no pulse shorter than 4 clk.
- Collision and last-write-wins:
  - Case 1: write D = 1, then D = 5 before the boundary. Only D = 5 is applied, giving a period of 12.
  - Case 2: a write that coincides with a falling-toggle edge is applied at the next falling toggle.
- Mid-operation reset: assert rst_n during a Sys_Clk1 high phase. Required response:
  - Sys_Clk1 = 0 and Sys_ClkN_Rst = 1 immediately.
  - Pending write discarded.
  - After release, the divisor is back to DIV1_INIT (period 24).
- Extreme divisor: D = 255 on channel 1 gives a period of 512 clk with exact 256/256 duty; cfg_wr during rst_n = 0 has no effect.
